// File: rtl/memory_stage.sv
// Pipeline memory stage: issues loads/stores over a ready-based data-memory
// handshake, stalls upstream while an access is outstanding and registers
// the result into the memory/writeback boundary.
// Optional access timeout: define MEM_TIMEOUT_EN.
module memory_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              wbs_in,
    input  logic              wme_in,
    input  logic              mm_in,
    input  logic              wm_in,
    input  logic              ni_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              valid_out,
    output logic              wbs_out,
    output logic              wm_out,
    output logic              ni_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              mem_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state;
    logic   mem_op;
    logic   timeout_hit;
    logic   wbs_lat;
    logic   wm_lat;
    logic   ni_lat;

    // A store's writeback value is its address, widened to the data width.
    function automatic logic [DATA_W-1:0] zext_addr(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    assign mem_op   = valid_in & (wme_in | mm_in);
    assign dmem_req = (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    assign timeout_hit = (state == ACCESS) && !dmem_ready
                         && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // Stall is forced low during reset so every output reads 0 there.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    stall = mem_op;
                ACCESS:  stall = ~dmem_ready & ~timeout_hit;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            wbs_lat     <= 1'b0;
            wm_lat      <= 1'b0;
            ni_lat      <= 1'b0;
            valid_out   <= 1'b0;
            wbs_out     <= 1'b0;
            wm_out      <= 1'b0;
            ni_out      <= 1'b0;
            wb_data_out <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= '0;
            mem_err     <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            mem_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        // Capture the request; the writeback slot gets a bubble.
                        state       <= ACCESS;
                        dmem_we     <= wme_in;
                        dmem_addr   <= alu_result_in[ADDR_W-1:0];
                        dmem_wdata  <= mem_data_in;
                        wbs_lat     <= wbs_in;
                        wm_lat      <= wm_in;
                        ni_lat      <= ni_in;
                        valid_out   <= 1'b0;
                        wbs_out     <= 1'b0;
                        wm_out      <= 1'b0;
                        ni_out      <= 1'b0;
                        wb_data_out <= '0;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end else begin
                        valid_out   <= valid_in;
                        wbs_out     <= valid_in & wbs_in;
                        wm_out      <= valid_in & wm_in;
                        ni_out      <= valid_in & ni_in;
                        wb_data_out <= valid_in ? alu_result_in : '0;
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        state       <= IDLE;
                        valid_out   <= 1'b1;
                        wbs_out     <= wbs_lat;
                        wm_out      <= wm_lat;
                        ni_out      <= ni_lat;
                        wb_data_out <= dmem_we ? zext_addr(dmem_addr) : dmem_rdata;
                    end else if (timeout_hit) begin
                        // Abort: retire the instruction without a register write.
                        state       <= IDLE;
                        valid_out   <= 1'b1;
                        wbs_out     <= 1'b0;
                        wm_out      <= wm_lat;
                        ni_out      <= ni_lat;
                        wb_data_out <= '0;
`ifdef MEM_TIMEOUT_EN
                        mem_err     <= 1'b1;
`endif
                    end else begin
                        valid_out   <= 1'b0;
                        wbs_out     <= 1'b0;
                        wm_out      <= 1'b0;
                        ni_out      <= 1'b0;
                        wb_data_out <= '0;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt    <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table for single-cycle ops plus
// hand-written sequences for loads, stores, wait states, reset and timeout.
module tb_memory_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 15;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, wbs_in = 1'b0, wme_in = 1'b0, mm_in = 1'b0;
    logic        wm_in = 1'b0, ni_in = 1'b0;
    logic [15:0] alu_result_in = '0, mem_data_in = '0, dmem_rdata = '0;
    logic        dmem_ready = 1'b0;
    logic        stall, dmem_req, dmem_we, valid_out, wbs_out, wm_out, ni_out, mem_err;
    logic [15:0] dmem_addr, dmem_wdata, wb_data_out;

    int total = 0;
    int passed = 0;

    memory_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .wbs_in(wbs_in),
        .wme_in(wme_in), .mm_in(mm_in), .wm_in(wm_in), .ni_in(ni_in),
        .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .valid_out(valid_out), .wbs_out(wbs_out),
        .wm_out(wm_out), .ni_out(ni_out), .wb_data_out(wb_data_out),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic wbs, input logic wme, input logic mm,
                          input logic [15:0] alu, input logic [15:0] wdat);
        valid_in = v; wbs_in = wbs; wme_in = wme; mm_in = mm;
        wm_in = 1'b0; ni_in = 1'b0; alu_result_in = alu; mem_data_in = wdat;
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic wbs, input logic [15:0] d);
        chk({tag, "_valid"}, 32'(valid_out), 32'(v));
        chk({tag, "_wbs"}, 32'(wbs_out), 32'(wbs));
        chk({tag, "_data"}, 32'(wb_data_out), 32'(d));
    endtask

    typedef struct {
        logic v, wbs, wm, ni, rdy;
        logic [15:0] alu;
        logic e_v, e_wbs, e_wm, e_ni;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

        // Reset state, with a memory op presented at the inputs.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000);
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(wb_data_out), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        rst_n = 1'b1;

        // Non-memory ops and bubbles.
        for (int i = 0; i < 6; i++) begin
            set_op(vecs[i].v, vecs[i].wbs, 1'b0, 1'b0, vecs[i].alu, 16'h0000);
            wm_in = vecs[i].wm; ni_in = vecs[i].ni; dmem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            chk($sformatf("vec%0d_req", i), 32'(dmem_req), 32'd0);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(vecs[i].e_v));
            chk($sformatf("vec%0d_wbs", i), 32'(wbs_out), 32'(vecs[i].e_wbs));
            chk($sformatf("vec%0d_wm", i), 32'(wm_out), 32'(vecs[i].e_wm));
            chk($sformatf("vec%0d_ni", i), 32'(ni_out), 32'(vecs[i].e_ni));
            chk($sformatf("vec%0d_data", i), 32'(wb_data_out), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_req_after", i), 32'(dmem_req), 32'd0);
        end
        dmem_ready = 1'b0;

        // Load, zero wait, followed by an ALU op held behind it.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000);
        #1;
        chk("ld_issue_stall", 32'(stall), 32'd1);
        chk("ld_issue_req", 32'(dmem_req), 32'd0);
        tick();
        chk("ld_acc_req", 32'(dmem_req), 32'd1);
        chk("ld_acc_addr", 32'(dmem_addr), 32'h0040);
        chk("ld_acc_we", 32'(dmem_we), 32'd0);
        chk("ld_acc_bubble", 32'(valid_out), 32'd0);
        dmem_ready = 1'b1; dmem_rdata = 16'hBEEF;
        #1;
        chk("ld_acc_stall", 32'(stall), 32'd0);
        tick();
        chk_wb("ld_done", 1'b1, 1'b1, 16'hBEEF);
        chk("ld_done_req", 32'(dmem_req), 32'd0);
        dmem_ready = 1'b0; dmem_rdata = 16'h0000;
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000);
        #1;
        chk("alu_after_ld_stall", 32'(stall), 32'd0);
        tick();
        chk_wb("alu_after_ld", 1'b1, 1'b1, 16'h0005);
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        chk("no_dup_valid", 32'(valid_out), 32'd0);

        // Store with three wait cycles; input bus scrambled to prove latching.
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234);
        #1;
        chk("st_issue_stall", 32'(stall), 32'd1);
        tick();
        alu_result_in = 16'hDEAD; mem_data_in = 16'hDEAD; wme_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            dmem_ready = (c == 3);
            #1;
            chk($sformatf("st_c%0d_req", c), 32'(dmem_req), 32'd1);
            chk($sformatf("st_c%0d_addr", c), 32'(dmem_addr), 32'h0010);
            chk($sformatf("st_c%0d_wdata", c), 32'(dmem_wdata), 32'h1234);
            chk($sformatf("st_c%0d_we", c), 32'(dmem_we), 32'd1);
            chk($sformatf("st_c%0d_stall", c), 32'(stall), (c == 3) ? 32'd0 : 32'd1);
            chk($sformatf("st_c%0d_valid", c), 32'(valid_out), 32'd0);
            tick();
        end
        dmem_ready = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk_wb("st_done", 1'b1, 1'b0, 16'h0010);
        chk("st_done_req", 32'(dmem_req), 32'd0);

        // wme and mm both set behaves as a store.
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0077, 16'h5555);
        tick();
        chk("both_we", 32'(dmem_we), 32'd1);
        dmem_ready = 1'b1; dmem_rdata = 16'h9999;
        tick();
        dmem_ready = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk_wb("both_done", 1'b1, 1'b1, 16'h0077);

        // Asynchronous reset in the middle of an access.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
        tick();
        chk("rstmid_req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(dmem_req), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_addr", 32'(dmem_addr), 32'd0);
        chk("rstmid_valid", 32'(valid_out), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rstmid_restart_req", 32'(dmem_req), 32'd1);
        dmem_ready = 1'b1; dmem_rdata = 16'h0C0D;
        tick();
        dmem_ready = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk_wb("rstmid_after", 1'b1, 1'b1, 16'h0C0D);

`ifdef MEM_TIMEOUT_EN
        // Access abandoned after TIMEOUT cycles without ready.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000);
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("to_c%0d_req", c), 32'(dmem_req), 32'd1);
            chk($sformatf("to_c%0d_stall", c), 32'(stall), (c == 3) ? 32'd0 : 32'd1);
            chk($sformatf("to_c%0d_err", c), 32'(mem_err), 32'd0);
            tick();
        end
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("to_err", 32'(mem_err), 32'd1);
        chk_wb("to_done", 1'b1, 1'b0, 16'h0000);
        chk("to_req", 32'(dmem_req), 32'd0);
        tick();
        chk("to_err_pulse", 32'(mem_err), 32'd0);
        chk("to_idle_req", 32'(dmem_req), 32'd0);
`else
        // Without the timeout the access waits indefinitely.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000);
        tick();
        for (int c = 0; c < 20; c++) tick();
        chk("notimeout_req", 32'(dmem_req), 32'd1);
        chk("notimeout_stall", 32'(stall), 32'd1);
        chk("notimeout_err", 32'(mem_err), 32'd0);
        dmem_ready = 1'b1; dmem_rdata = 16'h1111;
        tick();
        dmem_ready = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk_wb("notimeout_done", 1'b1, 1'b1, 16'h1111);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
